// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: timing defaults, width helper, hold-phase encoding.
package board_io_pkg;

  localparam int DEB_TICKS_DEFAULT = 4;
  // 50 MHz clock -> 1 ms filter tick
  localparam int PRESCALE_1MS      = 50000;

  typedef enum logic [1:0] {
    WAIT_LONG = 2'd0,
    REPEAT    = 2'd1,
    DONE      = 2'd2
  } hold_phase_e;

  // Bits needed to hold values 0..v-1, never less than 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One debounce channel: 2-flop sync, tick-driven filter, hold FSM, event pulses.
module pb_debounce_chan
  import board_io_pkg::*;
#(
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 0,
  parameter int REPEAT_TICKS   = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic pb_i,
  output logic state_o,
  output logic press_p_o,
  output logic release_p_o,
  output logic long_p_o,
  output logic rep_p_o
);

  localparam int DW   = clog2(DEBOUNCE_TICKS) + 1;
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = clog2(HMAX + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] L_LAST = HW'((LONG_TICKS > 0) ? LONG_TICKS - 1 : 0);
  localparam logic [HW-1:0] R_LAST = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam bit LONG_EN = (LONG_TICKS > 0);
  localparam bit REP_EN  = (REPEAT_TICKS > 0);

  logic          s0_q, s1_q;
  logic          state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          flip;
  logic          press_q, press_d, rel_q, rel_d;
  hold_phase_e   phase_q, phase_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_q, long_d, rep_q, rep_d;
  logic          hclr;

  // Synchroniser; polarity folded into the first stage so s1 is always active-high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= pb_i ^ ACTIVE_LOW;
      s1_q <= s0_q;
    end
  end

  // Filter: any agreement restarts, DEBOUNCE_TICKS disagreeing ticks flip state
  always_comb begin
    dcnt_d = dcnt_q;
    flip   = 1'b0;
    if (s1_q == state_q) begin
      dcnt_d = '0;
    end else if (tick_i) begin
      if (dcnt_q == D_LAST) begin
        flip   = 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign state_d = state_q ^ flip;
  assign press_d = flip & ~state_q;
  assign rel_d   = flip & state_q;

  // Filter state and edge pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= 1'b0;
      dcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Hold counting starts only once state is registered high, and a release
  // edge clears it in the same cycle so no late long/repeat slips out.
  assign hclr = ~state_q | rel_d;

  // Hold FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= WAIT_LONG;
      hcnt_q  <= '0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hcnt_q  <= hcnt_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  // Hold FSM next state
  always_comb begin
    phase_d = phase_q;
    hcnt_d  = hcnt_q;
    if (hclr) begin
      phase_d = WAIT_LONG;
      hcnt_d  = '0;
    end else if (tick_i) begin
      unique case (phase_q)
        WAIT_LONG: if (LONG_EN) begin
          if (hcnt_q == L_LAST) begin
            hcnt_d  = '0;
            phase_d = REP_EN ? REPEAT : DONE;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        REPEAT: hcnt_d = (hcnt_q == R_LAST) ? '0 : hcnt_q + 1'b1;
        DONE:   hcnt_d = hcnt_q;
        default: begin
          phase_d = WAIT_LONG;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // Hold FSM outputs (registered one-cycle pulses)
  always_comb begin
    long_d = LONG_EN & ~hclr & tick_i & (phase_q == WAIT_LONG) & (hcnt_q == L_LAST);
    rep_d  = REP_EN  & ~hclr & tick_i & (phase_q == REPEAT)    & (hcnt_q == R_LAST);
  end

  assign state_o     = state_q;
  assign press_p_o   = press_q;
  assign release_p_o = rel_q;
  assign long_p_o    = long_q;
  assign rep_p_o     = rep_q;

endmodule

// File: rtl/pb_debounce_bank.sv
// Bank of N push-button debouncers sharing one prescaled filter tick.
module pb_debounce_bank
  import board_io_pkg::*;
#(
  parameter int N              = 4,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int PRESCALE       = 1,
  parameter int DEBOUNCE_TICKS = DEB_TICKS_DEFAULT,
  parameter int LONG_TICKS     = 0,
  parameter int REPEAT_TICKS   = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] pb_i,
  output logic [N-1:0] state_o,
  output logic [N-1:0] press_p_o,
  output logic [N-1:0] release_p_o,
  output logic [N-1:0] long_p_o,
  output logic [N-1:0] rep_p_o
);

  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick;

  assign tick   = (pcnt_q == P_LAST);
  assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

  // Free-running prescaler, wraps on the tick cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    pb_debounce_chan #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick_i     (tick),
      .pb_i       (pb_i[g]),
      .state_o    (state_o[g]),
      .press_p_o  (press_p_o[g]),
      .release_p_o(release_p_o[g]),
      .long_p_o   (long_p_o[g]),
      .rep_p_o    (rep_p_o[g])
    );
  end

endmodule
